// File: rtl/instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_encoder                                                |
// | Description : Packs R/I/J field sets into 32-bit words and writes them to  |
// |               sequential instruction-memory addresses.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        imem_ack,
    output logic [15:0] count,
    output logic        full,
    output logic        err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    localparam logic [1:0] c_fmt_r    = 2'b00;
    localparam logic [1:0] c_fmt_i    = 2'b01;
    localparam logic [1:0] c_fmt_j    = 2'b10;

    // Widened by one bit so DEPTH = 65536 still compares correctly.
    localparam logic [16:0] c_depth   = 17'(DEPTH);

    logic [1:0]  r_state;
    logic        r_in_ready;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_count;
    logic        r_err;

    logic [1:0]  w_state_nxt;
    logic        w_in_ready_nxt;
    logic        w_we_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;
    logic [15:0] w_count_nxt;
    logic        w_err_nxt;

    logic        w_xfer;
    logic        w_commit;
    logic        w_illegal;
    logic [31:0] w_enc;
    logic [16:0] w_count_inc;

    assign w_xfer      = in_valid & r_in_ready;
    assign w_commit    = r_we & imem_ack;
    assign w_illegal   = (fmt == 2'b11);
    assign w_count_inc = {1'b0, r_count} + 17'd1;

    always_comb begin
        w_enc = 32'd0;
        case (fmt)
            c_fmt_r: w_enc = {opcode, rs, rt, rd, shamt, funct};
            c_fmt_i: w_enc = {opcode, rs, rt, imm};
            c_fmt_j: w_enc = {opcode, jaddr};
            default: w_enc = 32'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_count_nxt = r_count;
        w_err_nxt   = r_err;

        if (clear) begin
            // Clear overrides both a pending commit and a new transfer.
            w_state_nxt = c_st_idle;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = BASE_ADDR;
            w_count_nxt = 16'd0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_xfer) begin
                        if (w_illegal) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_state_nxt = c_st_write;
                            w_we_nxt    = 1'b1;
                            w_wdata_nxt = w_enc;
                        end
                    end
                end
                c_st_write: begin
                    if (w_commit) begin
                        w_we_nxt    = 1'b0;
                        w_addr_nxt  = r_addr + 32'd4;
                        w_count_nxt = w_count_inc[15:0];
                        w_state_nxt = (w_count_inc == c_depth) ? c_st_full : c_st_idle;
                    end
                end
                c_st_full: begin
                    w_state_nxt = c_st_full;
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_we_nxt    = 1'b0;
                end
            endcase
        end

        w_in_ready_nxt = (w_state_nxt == c_st_idle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= 32'd0;
            r_count    <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_count    <= w_count_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = (r_state == c_st_full);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_encoder                                             |
// | Description : Directed self-checking bench for instr_encoder (DEPTH = 4).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ack;
    logic [15:0] count;
    logic        full;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder #(
        .BASE_ADDR (32'h0000_0000),
        .DEPTH     (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm        (imm),
        .jaddr      (jaddr),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ack   (imem_ack),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
                              input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ja);
        fmt = f; opcode = op; rs = a; rt = b; rd = c; shamt = sh; funct = fn; imm = im; jaddr = ja;
    endtask

    task automatic send();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_we"},       32'(imem_we),  32'd0);
        check_eq({tag, "_addr"},     imem_addr,     32'h0);
        check_eq({tag, "_wdata"},    imem_wdata,    32'h0);
        check_eq({tag, "_count"},    32'(count),    32'd0);
        check_eq({tag, "_full"},     32'(full),     32'd0);
        check_eq({tag, "_err"},      32'(err),      32'd0);
    endtask

    initial begin
        int          commits;
        logic [31:0] seen_addr [4];

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; imem_ack = 1'b0;
        set_fields(2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        #23;
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();
        check_eq("rst_ready_rise", 32'(in_ready), 32'd1);

        // R-type with ack held high
        imem_ack = 1'b1;
        set_fields(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        send();
        check_eq("r_we",    32'(imem_we), 32'd1);
        check_eq("r_wdata", imem_wdata,   32'h0022_1820);
        check_eq("r_addr",  imem_addr,    32'h0);
        check_eq("r_ready", 32'(in_ready), 32'd0);
        tick();
        check_eq("r_count", 32'(count),   32'd1);
        check_eq("r_we_off", 32'(imem_we), 32'd0);
        check_eq("r_addr_inc", imem_addr, 32'h4);
        pulse_clear();
        check_eq("clr_count", 32'(count), 32'd0);
        check_eq("clr_addr",  imem_addr,  32'h0);

        // I-type then J-type
        set_fields(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
        send();
        check_eq("i_wdata", imem_wdata, 32'h2022_0005);
        check_eq("i_addr",  imem_addr,  32'h0);
        tick();
        set_fields(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10);
        send();
        check_eq("j_wdata", imem_wdata, 32'h0800_0010);
        check_eq("j_addr",  imem_addr,  32'h4);
        tick();
        check_eq("j_count", 32'(count), 32'd2);

        // Ack stall for five cycles, with a competing field set held on the inputs
        imem_ack = 1'b0;
        set_fields(2'b00, 6'h00, 5'd5, 5'd6, 5'd7, 5'd3, 6'h2A, 16'h0, 26'h0);
        send();
        set_fields(2'b10, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FF_FFFF);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_we",    32'(imem_we),  32'd1);
            check_eq("stall_addr",  imem_addr,     32'h8);
            check_eq("stall_wdata", imem_wdata,    32'h00A6_38EA);
            check_eq("stall_ready", 32'(in_ready), 32'd0);
            check_eq("stall_count", 32'(count),    32'd2);
            tick();
        end
        in_valid = 1'b0;
        imem_ack = 1'b1;
        tick();
        check_eq("stall_commit_count", 32'(count), 32'd3);
        check_eq("stall_commit_addr",  imem_addr,  32'hC);
        check_eq("stall_commit_ready", 32'(in_ready), 32'd1);
        check_eq("stall_commit_we",    32'(imem_we), 32'd0);

        // Illegal format, then clear
        set_fields(2'b11, 6'h01, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1);
        send();
        check_eq("ill_we",    32'(imem_we),  32'd0);
        check_eq("ill_err",   32'(err),      32'd1);
        check_eq("ill_ready", 32'(in_ready), 32'd1);
        check_eq("ill_count", 32'(count),    32'd3);
        tick();
        check_eq("ill_err_sticky", 32'(err), 32'd1);
        pulse_clear();
        check_eq("ill_clr_err",   32'(err),   32'd0);
        check_eq("ill_clr_count", 32'(count), 32'd0);
        check_eq("ill_clr_addr",  imem_addr,  32'h0);

        // Fill to DEPTH with in_valid held; the fifth word must not be taken
        commits = 0;
        set_fields(2'b10, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h55);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (imem_we && imem_ack) begin
                if (commits < 4) seen_addr[commits] = imem_addr;
                commits++;
            end
        end
        check_eq("full_commits", 32'(commits), 32'd4);
        for (int k = 0; k < 4; k++) check_eq("full_addr", seen_addr[k], 32'(k * 4));
        check_eq("full_flag",  32'(full),     32'd1);
        check_eq("full_count", 32'(count),    32'd4);
        check_eq("full_ready", 32'(in_ready), 32'd0);
        check_eq("full_we",    32'(imem_we),  32'd0);
        in_valid = 1'b0;
        pulse_clear();
        check_eq("full_clr_flag",  32'(full),     32'd0);
        check_eq("full_clr_ready", 32'(in_ready), 32'd1);

        // Clear coincident with a commit ack discards the pending word
        send();
        tick();
        check_eq("cc_pre_count", 32'(count), 32'd1);
        imem_ack = 1'b0;
        send();
        check_eq("cc_pending_addr", imem_addr, 32'h4);
        clear = 1'b1;
        imem_ack = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("cc_count", 32'(count),   32'd0);
        check_eq("cc_addr",  imem_addr,    32'h0);
        check_eq("cc_we",    32'(imem_we), 32'd0);

        // Clear coincident with a transfer drops the transfer
        clear = 1'b1;
        in_valid = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check_eq("cx_we",    32'(imem_we),  32'd0);
        check_eq("cx_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset while a write is pending
        imem_ack = 1'b0;
        set_fields(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        send();
        check_eq("mid_we", 32'(imem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        imem_ack = 1'b1;
        #10;
        check_eq("mid_rst_hold_count", 32'(count), 32'd0);
        imem_ack = 1'b0;
        rst_n = 1'b1;
        tick();
        check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_count", 32'(count),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
